// File: rtl/clkmon_pkg.sv
// Shared definitions for the FPUCLK loopback monitor.
// State encoding (visible on STATE) and default timing parameters.
package clkmon_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_SETTLE    = 3'd1,
    ST_CHECK     = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  localparam int DEF_SETTLE_CYCLES = 1024;
  localparam int DEF_CHECK_CYCLES  = 256;
  localparam int DEF_MAX_ERRORS    = 4;
  localparam int DEF_CW            = 16;

endpackage

// File: rtl/sync2.sv
// Generic N-flop synchroniser with asynchronous active-high reset.
// Ports: clk_i, rst_i, d_i (async input), stg_o (all stages, [0] first).
module sync2 #(
  parameter int N = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         d_i,
  output logic [N-1:0] stg_o
);

  logic [N-1:0] stg_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stg_q <= '0;
    else       stg_q <= {stg_q[N-2:0], d_i};
  end

  assign stg_o = stg_q;

endmodule

// File: rtl/fpuclk_loopback_monitor.sv
// FSBCLK-domain checker of the looped-back FPUCLK pad; gates SYS_RST.
// Ports: FSBCLK, RST, LOCKED, CPUCLKr, FPUCLK_FB in; SYS_RST, CLK_OK,
// FAULT, PHASE, STATE out.
import clkmon_pkg::*;

module fpuclk_loopback_monitor #(
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int CHECK_CYCLES  = DEF_CHECK_CYCLES,
  parameter int MAX_ERRORS    = DEF_MAX_ERRORS,
  parameter int CW            = DEF_CW
) (
  input  logic       FSBCLK,
  input  logic       RST,
  input  logic       LOCKED,
  input  logic       CPUCLKr,
  input  logic       FPUCLK_FB,
  output logic       SYS_RST,
  output logic       CLK_OK,
  output logic       FAULT,
  output logic       PHASE,
  output logic [2:0] STATE
);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CHECK_LAST  = CW'(CHECK_CYCLES - 1);
  localparam logic [CW-1:0] MAX_ERR     = CW'(MAX_ERRORS);

  logic [1:0] lk_stg;
  logic [2:0] fb_stg;
  logic       lk;
  logic       sync_unused;

  sync2 #(.N(2)) u_lk_sync (
    .clk_i (FSBCLK),
    .rst_i (RST),
    .d_i   (LOCKED),
    .stg_o (lk_stg)
  );

  sync2 #(.N(3)) u_fb_sync (
    .clk_i (FSBCLK),
    .rst_i (RST),
    .d_i   (FPUCLK_FB),
    .stg_o (fb_stg)
  );

  assign lk          = lk_stg[1];
  assign sync_unused = lk_stg[0] ^ fb_stg[0];

  logic tgl_q, ph_q;

  // s2^s3 flags a toggle; s2^CPUCLKr is the pad polarity.
  always_ff @(posedge FSBCLK or posedge RST) begin
    if (RST) begin
      tgl_q <= 1'b0;
      ph_q  <= 1'b0;
    end else begin
      tgl_q <= fb_stg[1] ^ fb_stg[2];
      ph_q  <= fb_stg[1] ^ CPUCLKr;
    end
  end

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] err_q, err_d;
  logic [CW-1:0] miss_q, miss_d;
  logic          ref_ph_q, ref_ph_d;
  logic          phase_q, phase_d;
  logic          sys_rst_q, sys_rst_d;
  logic          clk_ok_q, clk_ok_d;
  logic          fault_q, fault_d;

  logic          err_cyc;
  logic [CW-1:0] err_sum;
  logic [CW-1:0] miss_sum;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    miss_d   = miss_q;
    ref_ph_d = ref_ph_q;
    phase_d  = phase_q;

    err_cyc  = !tgl_q || (ph_q != ref_ph_q);
    err_sum  = err_q;
    if (err_cyc && err_q < MAX_ERR) err_sum = err_q + 1'b1;
    miss_sum = '0;
    if (!tgl_q) begin
      miss_sum = miss_q;
      if (miss_q < MAX_ERR) miss_sum = miss_q + 1'b1;
    end

    if (!lk) begin
      // Lock loss overrides everything, including FAULT.
      state_d = ST_WAIT_LOCK;
      cnt_d   = '0;
      err_d   = '0;
      miss_d  = '0;
    end else begin
      unique case (state_q)
        ST_WAIT_LOCK: begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
        ST_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d  = ST_CHECK;
            cnt_d    = '0;
            err_d    = '0;
            ref_ph_d = ph_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_CHECK: begin
          err_d = err_sum;
          if (cnt_q == CHECK_LAST) begin
            cnt_d = '0;
            err_d = '0;
            if (err_sum < MAX_ERR) begin
              state_d = ST_RUN;
              phase_d = ref_ph_q;
              miss_d  = '0;
            end else begin
              state_d = ST_FAULT;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          miss_d = miss_sum;
          if (miss_sum >= MAX_ERR) begin
            state_d = ST_FAULT;
            miss_d  = '0;
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_WAIT_LOCK;
      endcase
    end

    // Release only once RUN has been held for a full cycle; reassert
    // on the same edge that leaves RUN.
    sys_rst_d = !(state_q == ST_RUN && state_d == ST_RUN);
    clk_ok_d  = !sys_rst_d;
    fault_d   = (state_d == ST_FAULT);
  end

  always_ff @(posedge FSBCLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_WAIT_LOCK;
      cnt_q     <= '0;
      err_q     <= '0;
      miss_q    <= '0;
      ref_ph_q  <= 1'b0;
      phase_q   <= 1'b0;
      sys_rst_q <= 1'b1;
      clk_ok_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      miss_q    <= miss_d;
      ref_ph_q  <= ref_ph_d;
      phase_q   <= phase_d;
      sys_rst_q <= sys_rst_d;
      clk_ok_q  <= clk_ok_d;
      fault_q   <= fault_d;
    end
  end

  assign SYS_RST = sys_rst_q;
  assign CLK_OK  = clk_ok_q;
  assign FAULT   = fault_q;
  assign PHASE   = phase_q;
  assign STATE   = state_q;

endmodule

// File: tb/tb_fpuclk_loopback_monitor.sv
// Directed bench for fpuclk_loopback_monitor.
// SETTLE=16, CHECK=8, MAX=4; FPUCLK_FB derived from CPUCLKr.
module tb_fpuclk_loopback_monitor;

  logic       FSBCLK = 1'b0;
  logic       RST = 1'b1;
  logic       LOCKED = 1'b0;
  logic       CPUCLKr = 1'b0;
  logic       FPUCLK_FB = 1'b0;
  logic       SYS_RST, CLK_OK, FAULT, PHASE;
  logic [2:0] STATE;

  int n_vec = 0;
  int n_miss = 0;

  // stimulus model state
  logic        inv = 1'b0;
  logic        slip = 1'b0;
  logic        fb_stuck = 1'b0;
  int          cyc_n = 0;
  int          skip_base = 0;
  logic [31:0] skip_pat = '0;
  int          ok_cnt = 0;
  int          ok_base;
  logic        exp_ph;

  fpuclk_loopback_monitor #(
    .SETTLE_CYCLES (16),
    .CHECK_CYCLES  (8),
    .MAX_ERRORS    (4),
    .CW            (16)
  ) dut (
    .FSBCLK    (FSBCLK),
    .RST       (RST),
    .LOCKED    (LOCKED),
    .CPUCLKr   (CPUCLKr),
    .FPUCLK_FB (FPUCLK_FB),
    .SYS_RST   (SYS_RST),
    .CLK_OK    (CLK_OK),
    .FAULT     (FAULT),
    .PHASE     (PHASE),
    .STATE     (STATE)
  );

  always #5 FSBCLK = ~FSBCLK;

  // CPUCLKr toggles every cycle; each set bit of skip_pat drops one
  // FPUCLK_FB toggle (slips its phase by one cycle).
  always @(posedge FSBCLK) begin
    int d;
    #1;
    cyc_n++;
    d = cyc_n - skip_base;
    if (d >= 1 && d <= 32 && skip_pat[d-1]) slip = ~slip;
    CPUCLKr = ~CPUCLKr;
    FPUCLK_FB = fb_stuck ? 1'b0 : (CPUCLKr ^ inv ^ slip);
  end

  always @(negedge FSBCLK) if (CLK_OK === 1'b1) ok_cnt++;

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge FSBCLK);
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget,
                            input string tag);
    int i = 0;
    while (STATE !== st && i < budget) begin
      @(negedge FSBCLK);
      i++;
    end
    check(tag, STATE, st);
  endtask

  task automatic skip(input logic [31:0] pat);
    skip_base = cyc_n;
    skip_pat  = pat;
  endtask

  initial begin
    // reset values
    cyc(3);
    check("rst_sysrst", SYS_RST, 1);
    check("rst_clkok", CLK_OK, 0);
    check("rst_fault", FAULT, 0);
    check("rst_phase", PHASE, 0);
    check("rst_state", STATE, 0);
    RST = 1'b0;
    cyc(3);
    check("idle_state", STATE, 0);

    // nominal bring-up, in-phase pad
    LOCKED = 1'b1;
    cyc(2);
    check("t0p2_state", STATE, 0);
    cyc(1);
    check("t0p3_state", STATE, 1);
    cyc(15);
    check("settle_end", STATE, 1);
    cyc(1);
    check("check_ent", STATE, 2);
    cyc(7);
    check("check_end", STATE, 2);
    cyc(1);
    check("run_ent", STATE, 3);
    check("run_ent_rst", SYS_RST, 1);
    check("run_ent_ok", CLK_OK, 0);
    cyc(1);
    check("run_rst", SYS_RST, 0);
    check("run_ok", CLK_OK, 1);
    check("run_phase0", PHASE, 0);

    // run-time misses: 3 tolerated, 4 fault
    skip(32'b111);
    cyc(12);
    check("miss3_state", STATE, 3);
    check("miss3_ok", CLK_OK, 1);
    skip(32'b11111);
    wait_state(4, 15, "miss4_state");
    check("miss4_rst", SYS_RST, 1);
    check("miss4_ok", CLK_OK, 0);
    check("miss4_fault", FAULT, 1);
    cyc(4);
    check("fault_sticky", STATE, 4);

    // FAULT cleared only by lock loss
    LOCKED = 1'b0;
    cyc(3);
    check("flk_state", STATE, 0);
    check("flk_fault", FAULT, 0);
    check("flk_rst", SYS_RST, 1);

    // bring-up with inverted pad
    inv = 1'b1;
    exp_ph = inv ^ slip;
    LOCKED = 1'b1;
    wait_state(3, 40, "inv_run");
    cyc(1);
    check("inv_ok", CLK_OK, 1);
    check("inv_phase", PHASE, exp_ph);
    inv = 1'b0;
    cyc(10);
    check("phchg_state", STATE, 3);
    check("phchg_phase", PHASE, exp_ph);

    // lock loss in RUN
    LOCKED = 1'b0;
    cyc(3);
    check("lkrun_state", STATE, 0);
    check("lkrun_rst", SYS_RST, 1);
    check("lkrun_ok", CLK_OK, 0);

    // lock loss mid-SETTLE
    LOCKED = 1'b1;
    cyc(8);
    check("lkset_pre", STATE, 1);
    LOCKED = 1'b0;
    cyc(3);
    check("lkset_state", STATE, 0);

    // lock loss mid-CHECK
    LOCKED = 1'b1;
    wait_state(2, 30, "lkchk_pre");
    cyc(1);
    LOCKED = 1'b0;
    cyc(3);
    check("lkchk_state", STATE, 0);
    check("lkchk_rst", SYS_RST, 1);

    // stuck pad
    fb_stuck = 1'b1;
    ok_base = ok_cnt;
    LOCKED = 1'b1;
    wait_state(4, 40, "stuck_state");
    check("stuck_fault", FAULT, 1);
    check("stuck_rst", SYS_RST, 1);
    check("stuck_okseen", 8'(ok_cnt - ok_base), 0);
    LOCKED = 1'b0;
    cyc(3);
    fb_stuck = 1'b0;
    check("stuck_clr", FAULT, 0);

    // 3 error cycles inside the window -> RUN
    LOCKED = 1'b1;
    wait_state(2, 30, "e3_chk");
    skip(32'b101);
    wait_state(3, 12, "e3_run");
    LOCKED = 1'b0;
    cyc(3);

    // 4 error cycles, last on the final window cycle -> FAULT
    LOCKED = 1'b1;
    wait_state(2, 30, "e4_chk");
    skip(32'b1001);
    cyc(8);
    check("e4_state", STATE, 4);
    check("e4_fault", FAULT, 1);
    check("e4_ok", CLK_OK, 0);
    LOCKED = 1'b0;
    cyc(3);

    // lock loss coincident with CHECK completion
    LOCKED = 1'b1;
    wait_state(2, 30, "simc_chk");
    cyc(5);
    LOCKED = 1'b0;
    cyc(3);
    check("simc_state", STATE, 0);
    check("simc_ok", CLK_OK, 0);
    check("simc_rst", SYS_RST, 1);

    // lock loss coincident with 4th consecutive run miss
    LOCKED = 1'b1;
    wait_state(3, 40, "simr_run");
    cyc(2);
    skip(32'b1111);
    cyc(5);
    LOCKED = 1'b0;
    cyc(3);
    check("simr_state", STATE, 0);
    check("simr_fault", FAULT, 0);
    check("simr_rst", SYS_RST, 1);

    // short async reset pulse in RUN
    LOCKED = 1'b1;
    wait_state(3, 40, "arst_run");
    cyc(2);
    check("arst_pre", SYS_RST, 0);
    #2 RST = 1'b1;
    #1;
    check("arst_rst", SYS_RST, 1);
    check("arst_state", STATE, 0);
    check("arst_ok", CLK_OK, 0);
    check("arst_phase", PHASE, 0);
    #1 RST = 1'b0;
    @(negedge FSBCLK);
    check("arst_after", STATE, 0);
    wait_state(3, 40, "arst_requal");
    cyc(1);
    check("arst_ok2", CLK_OK, 1);
    check("arst_rst2", SYS_RST, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
